// File: rtl/scsi_dev_resp.sv
// SCSI device-side responder: indirect register file, one-byte-per-DACK DMA
// engine with gap timing, checksum on host writes and interrupt/status reporting.
module scsi_dev_resp #(
  parameter int unsigned DREQ_GAP = 2,
  parameter logic [7:0]  PAT_XOR  = 8'hA5
) (
  input  logic       CPUCLK,
  input  logic       RESET_,
  input  logic       CS_i,
  input  logic       RE_i,
  input  logic       WE_i,
  input  logic       DACK_i,
  input  logic       A0_i,
  input  logic [7:0] D_i,
  output logic [7:0] D_o,
  output logic       D_OE,
  output logic       DREQ_,
  output logic       INTRQ
);

  typedef enum logic [2:0] {IDLE, GAP, REQ, ACK, DONE} state_t;

  localparam logic [3:0] GAP_LAST = 4'(DREQ_GAP - 1);

  state_t      state, state_n;
  logic        cs_q, re_q, we_q, dack_q;
  logic        sel, sel_q, stb, cs_stb, dma_stb, conflict;
  logic        cs_wr, cs_rd, cmd_wr, abort, start, bad_cmd, stat_rd, done_entry;
  logic [4:0]  addr;
  logic [23:0] tc;
  logic [7:0]  idx, status, csum, rd_val;
  logic        dir;
  logic [3:0]  gap_cnt;
  logic [7:0]  mem [32];

  // A strobe is the first cycle a qualified read/write is seen.
  assign sel      = (RE_i | WE_i) & (CS_i | DACK_i);
  assign sel_q    = (re_q | we_q) & (cs_q | dack_q);
  assign stb      = sel & ~sel_q;
  assign cs_stb   = stb & CS_i;
  assign dma_stb  = stb & DACK_i & ~CS_i & (state == REQ);
  assign conflict = stb & CS_i & DACK_i;

  assign cs_wr   = cs_stb & WE_i;
  assign cs_rd   = cs_stb & RE_i & A0_i;
  assign cmd_wr  = cs_wr & A0_i & (addr == 5'h18);
  assign abort   = cmd_wr & (D_i == 8'h01);
  assign start   = cmd_wr & ((D_i == 8'h20) | (D_i == 8'h21)) & (state == IDLE);
  assign bad_cmd = cmd_wr & (D_i != 8'h01) & (D_i != 8'h20) & (D_i != 8'h21);
  assign stat_rd = cs_rd & (addr == 5'h17);

  assign D_OE  = RE_i & (CS_i | DACK_i);
  assign DREQ_ = (state != REQ);

  always_comb begin
    rd_val = mem[addr];
    case (addr)
      5'h12:   rd_val = tc[23:16];
      5'h13:   rd_val = tc[15:8];
      5'h14:   rd_val = tc[7:0];
      5'h17:   rd_val = status;
      5'h1A:   rd_val = csum;
      default: rd_val = mem[addr];
    endcase
  end

  always_comb begin
    D_o = '0;
    if (CS_i)        D_o = A0_i ? rd_val : {3'b000, addr};
    else if (DACK_i) D_o = idx ^ PAT_XOR;
  end

  always_ff @(posedge CPUCLK or negedge RESET_) begin
    if (!RESET_) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = (tc == '0) ? DONE : GAP;
      GAP:  if (gap_cnt == GAP_LAST) state_n = REQ;
      REQ:  if (dma_stb) state_n = ACK;
      ACK:  if (!DACK_i) state_n = (tc == '0) ? DONE : GAP;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
    done_entry = (state_n == DONE) && (state != DONE);
  end

  always_ff @(posedge CPUCLK or negedge RESET_) begin
    if (!RESET_) begin
      {cs_q, re_q, we_q, dack_q} <= '0;
      addr    <= '0;
      tc      <= '0;
      idx     <= '0;
      status  <= '0;
      csum    <= '0;
      dir     <= 1'b0;
      gap_cnt <= '0;
      INTRQ   <= 1'b0;
      for (int unsigned i = 0; i < 32; i++) mem[i] <= '0;
    end else begin
      cs_q    <= CS_i;
      re_q    <= RE_i;
      we_q    <= WE_i;
      dack_q  <= DACK_i;
      gap_cnt <= (state == GAP) ? gap_cnt + 4'd1 : '0;

      if (cs_wr && !A0_i) addr <= D_i[4:0];
      if (cs_stb && A0_i) begin
        if (WE_i) begin
          case (addr)
            5'h12:        tc[23:16] <= D_i;
            5'h13:        tc[15:8]  <= D_i;
            5'h14:        tc[7:0]   <= D_i;
            5'h17, 5'h1A: ;
            default:      mem[addr] <= D_i;
          endcase
        end
        if (addr != 5'h17 && addr != 5'h18) addr <= addr + 5'd1;
      end

      if (start) begin
        idx  <= '0;
        csum <= '0;
        dir  <= D_i[0];
      end
      if (dma_stb) begin
        if (tc != '0) tc <= tc - 24'd1;
        idx <= idx + 8'd1;
        if (dir && WE_i) csum <= csum + D_i;
      end

      if (stat_rd)    INTRQ <= 1'b0;
      if (bad_cmd)    begin status <= 8'h42; INTRQ <= 1'b1; end
      if (abort)      begin status <= 8'h22; INTRQ <= 1'b1; end
      if (done_entry) begin status <= 8'h16; INTRQ <= 1'b1; end
      // Flag a lost DMA byte on top of whatever status this cycle produced.
      if (conflict)   status[7] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_scsi_dev_resp.sv
// Directed bench for scsi_dev_resp: reads are scored through an expected-value
// queue drained by a monitor; pin-level outputs are checked inline.
module tb_scsi_dev_resp;

  logic       CPUCLK = 1'b0;
  logic       RESET_, CS_i, RE_i, WE_i, DACK_i, A0_i;
  logic [7:0] D_i, D_o;
  logic       D_OE, DREQ_, INTRQ;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;
  exp_t sb[$];

  always #5 CPUCLK = ~CPUCLK;

  scsi_dev_resp #(.DREQ_GAP(2), .PAT_XOR(8'hA5)) dut (
    .CPUCLK(CPUCLK), .RESET_(RESET_), .CS_i(CS_i), .RE_i(RE_i), .WE_i(WE_i),
    .DACK_i(DACK_i), .A0_i(A0_i), .D_i(D_i), .D_o(D_o), .D_OE(D_OE),
    .DREQ_(DREQ_), .INTRQ(INTRQ)
  );

  always @(negedge CPUCLK) begin
    exp_t e;
    if (RESET_ === 1'b1 && D_OE === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: D_o=%02h with nothing expected", D_o);
      end else begin
        e = sb.pop_front();
        if (D_o !== e.exp) begin
          errors++;
          $display("FAIL %s: got %02h expected %02h", e.name, D_o, e.exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CPUCLK);
    #1;
  endtask

  task automatic reg_wr(input logic a0, input logic [7:0] d);
    CS_i = 1'b1; WE_i = 1'b1; A0_i = a0; D_i = d;
    cyc();
    CS_i = 1'b0; WE_i = 1'b0;
    cyc();
  endtask

  task automatic reg_rd(input logic a0, input logic [7:0] exp, input string name);
    sb.push_back('{name: name, exp: exp});
    CS_i = 1'b1; RE_i = 1'b1; A0_i = a0;
    cyc();
    CS_i = 1'b0; RE_i = 1'b0;
    cyc();
  endtask

  task automatic set_addr(input logic [7:0] a);
    reg_wr(1'b0, a);
  endtask

  task automatic rd_reg(input logic [7:0] a, input logic [7:0] exp, input string name);
    set_addr(a);
    reg_rd(1'b1, exp, name);
  endtask

  task automatic dack_rd(input logic [7:0] exp, input string name);
    sb.push_back('{name: name, exp: exp});
    DACK_i = 1'b1; RE_i = 1'b1;
    cyc();
    DACK_i = 1'b0; RE_i = 1'b0;
    chk({name, "_dreq_hi"}, {7'b0, DREQ_}, 8'h01);
    cyc();
  endtask

  task automatic dack_wr(input logic [7:0] d, input string name);
    DACK_i = 1'b1; WE_i = 1'b1; D_i = d;
    cyc();
    DACK_i = 1'b0; WE_i = 1'b0;
    chk({name, "_dreq_hi"}, {7'b0, DREQ_}, 8'h01);
    cyc();
  endtask

  // Counts cycles until DREQ_ falls; a command write already spends one GAP cycle.
  task automatic wait_dreq(input string name, input int exp_n);
    int n = 0;
    while (DREQ_ !== 1'b0 && n < 40) begin
      cyc();
      n++;
    end
    chk(name, 8'(n), 8'(exp_n));
  endtask

  task automatic no_dreq(input string name, input int cycles);
    int lows = 0;
    for (int i = 0; i < cycles; i++) begin
      if (DREQ_ !== 1'b1) lows++;
      cyc();
    end
    chk(name, 8'(lows), 8'h00);
  endtask

  task automatic set_tc(input logic [7:0] b2, input logic [7:0] b1, input logic [7:0] b0);
    set_addr(8'h12);
    reg_wr(1'b1, b2);
    reg_wr(1'b1, b1);
    reg_wr(1'b1, b0);
  endtask

  task automatic command(input logic [7:0] c);
    set_addr(8'h18);
    reg_wr(1'b1, c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RESET_ = 1'b0; CS_i = 1'b0; RE_i = 1'b0; WE_i = 1'b0;
    DACK_i = 1'b0; A0_i = 1'b0; D_i = '0;
    repeat (3) @(posedge CPUCLK);
    #1;
    chk("rst_dreq", {7'b0, DREQ_}, 8'h01);
    chk("rst_intrq", {7'b0, INTRQ}, 8'h00);
    RE_i = 1'b1; DACK_i = 1'b1;
    #1 chk("rst_doe_follows", {7'b0, D_OE}, 8'h01);
    RE_i = 1'b0; DACK_i = 1'b0;
    #1 chk("rst_doe_low", {7'b0, D_OE}, 8'h00);
    @(posedge CPUCLK); #1;
    RESET_ = 1'b1;
    cyc();
    rd_reg(8'h17, 8'h00, "status_after_reset");

    // Device-to-host DMA of three bytes
    set_tc(8'h00, 8'h00, 8'h03);
    command(8'h20);
    wait_dreq("rd_dreq_lat0", 1);
    dack_rd(8'hA5, "rd_byte0");
    wait_dreq("rd_dreq_lat1", 2);
    dack_rd(8'hA4, "rd_byte1");
    wait_dreq("rd_dreq_lat2", 2);
    dack_rd(8'hA7, "rd_byte2");
    chk("rd_intrq_set", {7'b0, INTRQ}, 8'h01);
    rd_reg(8'h17, 8'h16, "rd_status_done");
    chk("rd_intrq_cleared", {7'b0, INTRQ}, 8'h00);

    // Host-to-device DMA with checksum
    set_tc(8'h00, 8'h00, 8'h02);
    command(8'h21);
    wait_dreq("wr_dreq_lat0", 1);
    dack_wr(8'h10, "wr_byte0");
    wait_dreq("wr_dreq_gap", 2);
    dack_wr(8'hF5, "wr_byte1");
    chk("wr_intrq_set", {7'b0, INTRQ}, 8'h01);
    rd_reg(8'h1A, 8'h05, "wr_checksum");

    // Auto-increment with wrap, and status address holds ADDR
    set_addr(8'h1F);
    reg_wr(1'b1, 8'h3C);
    reg_wr(1'b1, 8'hC3);
    set_addr(8'h1F);
    reg_rd(1'b1, 8'h3C, "ainc_1f");
    reg_rd(1'b1, 8'hC3, "ainc_wrap_00");
    reg_rd(1'b0, 8'h01, "ainc_addr_01");
    set_addr(8'h17);
    reg_rd(1'b1, 8'h16, "status_rd_a");
    reg_rd(1'b1, 8'h16, "status_rd_b");
    reg_rd(1'b0, 8'h17, "status_addr_hold");

    // Abort after one of four bytes
    set_tc(8'h00, 8'h00, 8'h04);
    command(8'h20);
    wait_dreq("ab_dreq_lat", 1);
    dack_rd(8'hA5, "ab_byte0");
    command(8'h01);
    chk("ab_dreq_hi", {7'b0, DREQ_}, 8'h01);
    chk("ab_intrq", {7'b0, INTRQ}, 8'h01);
    no_dreq("ab_idle", 4);
    rd_reg(8'h17, 8'h22, "ab_status");
    set_addr(8'h12);
    reg_rd(1'b1, 8'h00, "ab_tc_hi");
    reg_rd(1'b1, 8'h00, "ab_tc_mid");
    reg_rd(1'b1, 8'h03, "ab_tc_lo");

    // Zero transfer count completes immediately
    set_tc(8'h00, 8'h00, 8'h00);
    command(8'h20);
    chk("tc0_intrq", {7'b0, INTRQ}, 8'h01);
    no_dreq("tc0_no_dreq", 6);
    rd_reg(8'h17, 8'h16, "tc0_status");

    // Simultaneous CS and DACK strobe, bad command, DACK outside REQ
    set_tc(8'h00, 8'h00, 8'h02);
    command(8'h20);
    wait_dreq("cf_dreq_lat", 1);
    sb.push_back('{name: "cf_addr_read", exp: 8'h18});
    CS_i = 1'b1; DACK_i = 1'b1; RE_i = 1'b1; A0_i = 1'b0;
    cyc();
    CS_i = 1'b0; DACK_i = 1'b0; RE_i = 1'b0;
    cyc();
    chk("cf_still_req", {7'b0, DREQ_}, 8'h00);
    rd_reg(8'h14, 8'h02, "cf_tc_unchanged");
    rd_reg(8'h17, 8'h96, "cf_status_bit7");
    command(8'h55);
    chk("bad_cmd_state", {7'b0, DREQ_}, 8'h00);
    chk("bad_cmd_intrq", {7'b0, INTRQ}, 8'h01);
    rd_reg(8'h17, 8'h42, "bad_cmd_status");
    command(8'h01);
    chk("cf_abort_dreq", {7'b0, DREQ_}, 8'h01);
    dack_rd(8'hA5, "idle_dack_data");
    rd_reg(8'h14, 8'h02, "idle_dack_tc");

    // Reset in the middle of a transfer
    set_tc(8'h00, 8'h00, 8'h03);
    command(8'h20);
    wait_dreq("mr_dreq_lat0", 1);
    dack_rd(8'hA5, "mr_byte0");
    wait_dreq("mr_dreq_lat1", 2);
    #2 RESET_ = 1'b0;
    #1 chk("mr_async_dreq", {7'b0, DREQ_}, 8'h01);
    chk("mr_intrq", {7'b0, INTRQ}, 8'h00);
    @(posedge CPUCLK); #1;
    RESET_ = 1'b1;
    cyc();
    no_dreq("mr_no_dreq", 4);
    rd_reg(8'h17, 8'h00, "mr_status");
    chk("mr_intrq_after", {7'b0, INTRQ}, 8'h00);
    rd_reg(8'h14, 8'h00, "mr_tc_cleared");
    rd_reg(8'h1F, 8'h00, "mr_mem_cleared");

    for (int i = 0; i < 10 && sb.size() != 0; i++) cyc();
    chk("scoreboard_drained", 8'(sb.size()), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
